csc_gen_ctrl: RTL and testbench
===============================

CSC_GEN_CTRL -- requirements
Module: csc_gen_ctrl

Interface
REQ-001 Parameter CHAOS_OVLD_W, default 32, is the random word width.
REQ-002 Parameter SUBCAR_NUM, default 16, is the number of subcarriers.
REQ-003 Parameter OFDM_SYM_NUM, default 16, is the number of OFDM symbols.
REQ-004 Parameter NNZ_PER_COL, default 4, is the number of nonzeros per column; it SHALL be a power of two ≤ MAT_RANK.
REQ-005 Derived values SHALL be: MAT_RANK=SUBCAR_NUM*OFDM_SYM_NUM (power of two); ROW_W=clog2(MAT_RANK); BANK=MAT_RANK/NNZ_PER_COL; PTR_W=clog2(MAT_RANK*NNZ_PER_COL+1).
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to generate one matrix.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the matrix is complete.
- rand_x1  in  CHAOS_OVLD_W  row-select random.
- rand_z1  in  CHAOS_OVLD_W  value random.
- rand_vld  in  1  random tuple valid.
- rand_rdy  out  1  random tuple ready.
- nz_vld  out  1  nonzero entry valid.
- nz_rdy  in  1  nonzero sink ready.
- nz_row  out  ROW_W  row index.
- nz_col  out  ROW_W  column index.
- nz_val  out  16  value, unsigned Q0.16.
- ptr_vld  out  1  column-pointer entry valid.
- ptr_rdy  in  1  pointer sink ready.
- ptr_idx  out  ROW_W+1  pointer index, 0..MAT_RANK.
- ptr_val  out  PTR_W  pointer value.

Function
REQ-007 FSM states SHALL be IDLE, PTR, EMIT, LAST_PTR and DONE.
- IDLE→PTR on start.
- PTR→EMIT on a ptr handshake.
- EMIT→PTR after the NNZ_PER_COL-th nonzero handshake of a column other than the last.
- EMIT→LAST_PTR after the last column's final nonzero handshake.
- LAST_PTR→DONE on a ptr handshake.
- DONE→IDLE unconditionally.
REQ-008 start SHALL be ignored in every state except IDLE.
REQ-009 In PTR, the block SHALL present ptr_idx=c and ptr_val=c*NNZ_PER_COL for the current column c. In LAST_PTR it SHALL present ptr_idx=MAT_RANK and ptr_val=MAT_RANK*NNZ_PER_COL.
REQ-010 ptr_vld SHALL be high in PTR and LAST_PTR. Once asserted, ptr_vld and its data SHALL hold stable until ptr_rdy.
REQ-011 rand_rdy SHALL equal (state==EMIT) && (!nz_vld || nz_rdy) && (fewer than NNZ_PER_COL tuples accepted in the current column). It SHALL be combinational from registered state and nz_rdy only.
REQ-012 The tuple accepted as the k-th of column c (k=0..NNZ_PER_COL-1) SHALL produce:
- nz_row = k*BANK + (rand_x1[CHAOS_OVLD_W-1 -: clog2(BANK)]), or k*BANK when BANK=1;
- nz_col = c;
- nz_val = rand_z1[CHAOS_OVLD_W-1 -: 16].
Rows within a column are therefore distinct and strictly ascending.
REQ-013 The nonzero output SHALL be registered. nz_vld SHALL rise the cycle after the rand handshake, and nz_* SHALL hold stable until nz_rdy.
REQ-014 The column counter SHALL advance only after the column's last nonzero handshake on the nz port, not on its rand acceptance. The next column's PTR entry SHALL never precede the previous column's last nz handshake.
REQ-015 Simultaneous nz handshake and new rand acceptance SHALL sustain one entry per cycle.
REQ-016 busy SHALL be high in PTR, EMIT, LAST_PTR and DONE, and low in IDLE.
REQ-017 Total output per run SHALL be exactly MAT_RANK+1 ptr entries and MAT_RANK*NNZ_PER_COL nz entries, in column order.

Reset
REQ-018 On rst_n low (asynchronous), the block SHALL clear the following, including mid-run:
- state to IDLE;
- the column and nonzero counters to 0;
- busy, done, rand_rdy, nz_vld and ptr_vld to 0;
- nz_row, nz_col, nz_val, ptr_idx and ptr_val to 0.
REQ-019 After reset release, no output SHALL assert until a new start.

Structure
REQ-020 A shared package mat_pkg SHALL hold:
- the FSM state encoding;
- the clog2 helper;
- the Q0.16 value width constant (16).
REQ-021 The registered valid/ready output stage for the nz stream SHALL be one sub-module, csc_out_reg, parameterised by data width.

Verification
REQ-022 Use SUBCAR_NUM=2, OFDM_SYM_NUM=2, NNZ_PER_COL=2 (MAT_RANK=4, BANK=2) unless noted.
REQ-023 Full run, sinks always ready, rand_vld=1, rand_x1=0x8000_0000, rand_z1=0x1234_0000 → the bench SHALL see:
- ptr (idx,val) sequence (0,0),(1,2),(2,4),(3,6),(4,8);
- each column rows {1,3} with nz_val=0x1234;
- done pulses exactly once.
REQ-024 nz_rdy low for 5 cycles mid-column → the bench SHALL see:
- nz_* held constant;
- rand_rdy=0 while nz_vld && !nz_rdy;
- no entry lost or duplicated.
REQ-025 ptr_rdy low for 3 cycles in PTR → the bench SHALL see ptr_vld held at 1 with stable data and rand_rdy=0 throughout.
REQ-026 start pulsed while busy → the bench SHALL see no effect on counters. A second start after done → a full second run with identical ptr sequence.
REQ-027 rst_n asserted during column 2 EMIT → the bench SHALL see:
- all outputs 0 immediately;
- after release, idle until start;
- the next run begins at ptr_idx=0.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the sparse-matrix generation blocks: controller
// state encoding, a constant-foldable ceiling-log2 helper and the width of
// the unsigned Q0.16 nonzero value.
package mat_pkg;

   // Width of an unsigned Q0.16 nonzero value.
   localparam int unsigned VAL_W = 16;

   // Controller states. Plain constants keep the encoding visible to
   // legacy tooling that probes the state register directly.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PTR      = 3'd1;
   localparam logic [2:0] ST_EMIT     = 3'd2;
   localparam logic [2:0] ST_LAST_PTR = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Ceiling log2; clog2(1) is 0. Usable in parameter elaboration.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/csc_out_reg.sv
// Single-entry registered valid/ready stage. Accepts a new word whenever the
// held word is absent or leaving in the same cycle, so back-to-back transfers
// sustain one word per clock while the output stays stable under back-pressure.
module csc_out_reg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data
);

   assign in_rdy = !out_vld || out_rdy;

   // Hold the current word until it is taken; reload on the same edge it leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (in_rdy) begin
         out_vld <= in_vld;
         if (in_vld) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/csc_gen_ctrl.sv
// Compressed-sparse-column matrix generator controller. For each column it
// emits a column-pointer entry, then NNZ_PER_COL nonzeros whose rows are drawn
// one per row bank from a random source; a final pointer closes the matrix.
module csc_gen_ctrl
   import mat_pkg::*;
#(
   parameter int unsigned CHAOS_OVLD_W = 32,
   parameter int unsigned SUBCAR_NUM   = 16,
   parameter int unsigned OFDM_SYM_NUM = 16,
   parameter int unsigned NNZ_PER_COL  = 4,
   localparam int unsigned MAT_RANK    = SUBCAR_NUM * OFDM_SYM_NUM,
   localparam int unsigned ROW_W       = clog2(MAT_RANK),
   localparam int unsigned BANK        = MAT_RANK / NNZ_PER_COL,
   localparam int unsigned PTR_W       = clog2(MAT_RANK * NNZ_PER_COL + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic [CHAOS_OVLD_W-1:0] rand_x1,
   input  logic [CHAOS_OVLD_W-1:0] rand_z1,
   input  logic                    rand_vld,
   output logic                    rand_rdy,
   output logic                    nz_vld,
   input  logic                    nz_rdy,
   output logic [ROW_W-1:0]        nz_row,
   output logic [ROW_W-1:0]        nz_col,
   output logic [VAL_W-1:0]        nz_val,
   output logic                    ptr_vld,
   input  logic                    ptr_rdy,
   output logic [ROW_W:0]          ptr_idx,
   output logic [PTR_W-1:0]        ptr_val
);

   localparam int unsigned BANK_W = clog2(BANK);
   localparam int unsigned CNT_W  = clog2(NNZ_PER_COL + 1);
   localparam int unsigned IDX_W  = ROW_W + 1;
   localparam int unsigned DATA_W = 2 * ROW_W + VAL_W;

   localparam logic [CNT_W-1:0] K_NUM    = CNT_W'(NNZ_PER_COL);
   localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(NNZ_PER_COL - 1);
   localparam logic [ROW_W-1:0] COL_LAST = ROW_W'(MAT_RANK - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(MAT_RANK);
   localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(NNZ_PER_COL);
   localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(MAT_RANK * NNZ_PER_COL);

   logic [2:0]        state;
   logic [ROW_W-1:0]  col;
   logic [CNT_W-1:0]  acc_cnt;   // tuples accepted into the current column
   logic [CNT_W-1:0]  nz_cnt;    // nonzeros handed off from the current column

   logic              accept_ok;
   logic              stage_rdy;
   logic              rand_fire;
   logic              nz_fire;
   logic              ptr_fire;
   logic [ROW_W-1:0]  row_base;
   logic [ROW_W-1:0]  row_next;
   logic [VAL_W-1:0]  val_next;
   logic [DATA_W-1:0] stage_in;
   logic [DATA_W-1:0] stage_out;
   logic              unused_rand;

   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);
   assign ptr_vld  = (state == ST_PTR) || (state == ST_LAST_PTR);

   assign accept_ok = (state == ST_EMIT) && (acc_cnt < K_NUM);
   assign rand_rdy  = accept_ok && stage_rdy;
   assign rand_fire = rand_vld && rand_rdy;
   assign nz_fire   = nz_vld && nz_rdy;
   assign ptr_fire  = ptr_vld && ptr_rdy;

   // Pointer payload; zero whenever no pointer is being offered.
   always_comb begin
      ptr_idx = '0;
      ptr_val = '0;
      if (state == ST_PTR) begin
         ptr_idx = IDX_W'(col);
         ptr_val = PTR_W'(col) * PTR_STEP;
      end else if (state == ST_LAST_PTR) begin
         ptr_idx = IDX_END;
         ptr_val = PTR_END;
      end
   end

   // Row banks are power-of-two sized, so bank offset and in-bank random
   // select occupy disjoint bits and OR is equivalent to the add.
   assign row_base = ROW_W'(acc_cnt) << BANK_W;
   generate
      if (BANK_W > 0) begin : g_bank_sel
         assign row_next = row_base | ROW_W'(rand_x1[CHAOS_OVLD_W-1 -: BANK_W]);
      end else begin : g_no_bank_sel
         assign row_next = row_base;
      end
   endgenerate

   assign val_next    = rand_z1[CHAOS_OVLD_W-1 -: VAL_W];
   assign stage_in    = {row_next, col, val_next};
   assign unused_rand = ^{rand_x1, rand_z1};

   csc_out_reg #(
      .DATA_W (DATA_W)
   ) u_nz_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rand_vld && accept_ok),
      .in_rdy   (stage_rdy),
      .in_data  (stage_in),
      .out_vld  (nz_vld),
      .out_rdy  (nz_rdy),
      .out_data (stage_out)
   );

   assign nz_row = stage_out[DATA_W-1 -: ROW_W];
   assign nz_col = stage_out[VAL_W +: ROW_W];
   assign nz_val = stage_out[VAL_W-1:0];

   // Sequencing: a column closes only when its last nonzero leaves the
   // output stage, so the next pointer never overtakes buffered data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         col     <= '0;
         acc_cnt <= '0;
         nz_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_PTR;
                  col     <= '0;
                  acc_cnt <= '0;
                  nz_cnt  <= '0;
               end
            end
            ST_PTR: begin
               if (ptr_fire) begin
                  state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (rand_fire) begin
                  acc_cnt <= acc_cnt + 1'b1;
               end
               if (nz_fire) begin
                  if (nz_cnt == K_LAST) begin
                     nz_cnt  <= '0;
                     acc_cnt <= '0;
                     if (col == COL_LAST) begin
                        state <= ST_LAST_PTR;
                     end else begin
                        col   <= col + 1'b1;
                        state <= ST_PTR;
                     end
                  end else begin
                     nz_cnt <= nz_cnt + 1'b1;
                  end
               end
            end
            ST_LAST_PTR: begin
               if (ptr_fire) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               col   <= '0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csc_gen_ctrl.sv
// Directed bench for csc_gen_ctrl at MAT_RANK=4, NNZ_PER_COL=2, BANK=2.
module tb_csc_gen_ctrl;

   localparam int unsigned W     = 32;
   localparam int unsigned ROW_W = 2;
   localparam int unsigned PTR_W = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             busy;
   logic             done;
   logic [W-1:0]     rand_x1;
   logic [W-1:0]     rand_z1;
   logic             rand_vld;
   logic             rand_rdy;
   logic             nz_vld;
   logic             nz_rdy;
   logic [ROW_W-1:0] nz_row;
   logic [ROW_W-1:0] nz_col;
   logic [15:0]      nz_val;
   logic             ptr_vld;
   logic             ptr_rdy;
   logic [ROW_W:0]   ptr_idx;
   logic [PTR_W-1:0] ptr_val;

   csc_gen_ctrl #(
      .CHAOS_OVLD_W (32),
      .SUBCAR_NUM   (2),
      .OFDM_SYM_NUM (2),
      .NNZ_PER_COL  (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rand_x1  (rand_x1),
      .rand_z1  (rand_z1),
      .rand_vld (rand_vld),
      .rand_rdy (rand_rdy),
      .nz_vld   (nz_vld),
      .nz_rdy   (nz_rdy),
      .nz_row   (nz_row),
      .nz_col   (nz_col),
      .nz_val   (nz_val),
      .ptr_vld  (ptr_vld),
      .ptr_rdy  (ptr_rdy),
      .ptr_idx  (ptr_idx),
      .ptr_val  (ptr_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int ptr_q[$];
   int nz_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after posedge, so the negedge sees what the next posedge sees.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ptr_vld && ptr_rdy) ptr_q.push_back((int'(ptr_idx) << 8) | int'(ptr_val));
         if (nz_vld && nz_rdy)   nz_q.push_back((int'(nz_row) << 20) | (int'(nz_col) << 16) | int'(nz_val));
         if (done)               done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      ptr_q.delete();
      nz_q.delete();
      done_cnt = 0;
   endtask

   task automatic start_run();
      clear_logs();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 300) begin
         step();
         n++;
      end
      check_val({tag, "_done_timeout"}, 32'(n < 300), 32'd1);
      step();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_ctl"}, {27'd0, busy, done, rand_rdy, nz_vld, ptr_vld}, 32'd0);
      check_val({tag, "_nz"},  {12'd0, nz_row, nz_col, nz_val}, 32'd0);
      check_val({tag, "_ptr"}, {25'd0, ptr_idx, ptr_val}, 32'd0);
   endtask

   // Expected: ptr (i, 2i) for i=0..4; nz rows k*2+row0 per column, fixed value.
   task automatic check_run(input string tag, input int row0, input int val);
      int got;
      check_val({tag, "_ptr_cnt"}, 32'(ptr_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         got = (i < ptr_q.size()) ? ptr_q[i] : -1;
         check_val($sformatf("%s_ptr%0d", tag, i), got, 32'((i << 8) | (2 * i)));
      end
      check_val({tag, "_nz_cnt"}, 32'(nz_q.size()), 32'd8);
      for (int j = 0; j < 8; j++) begin
         got = (j < nz_q.size()) ? nz_q[j] : -1;
         check_val($sformatf("%s_nz%0d", tag, j), got,
                   32'((((j % 2) * 2 + row0) << 20) | ((j / 2) << 16) | val));
      end
      check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [ROW_W-1:0] h_row;
      logic [ROW_W-1:0] h_col;
      logic [15:0]      h_val;

      rst_n    = 1'b0;
      start    = 1'b0;
      rand_vld = 1'b0;
      rand_x1  = '0;
      rand_z1  = '0;
      nz_rdy   = 1'b1;
      ptr_rdy  = 1'b1;
      repeat (2) step();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      rand_vld = 1'b1;
      repeat (3) step();
      check_outputs_zero("post_reset_idle");

      // Nominal run: top bit of x1 set -> rows 1,3.
      rand_x1 = 32'h8000_0000;
      rand_z1 = 32'h1234_0000;
      start_run();
      wait_done("t1");
      check_run("t1", 1, 16'h1234);

      // nz back-pressure mid-column; top bit clear -> rows 0,2.
      rand_x1 = 32'h4000_0000;
      rand_z1 = 32'hBEEF_0001;
      start_run();
      n = 0;
      while (!nz_vld && n < 50) begin
         step();
         n++;
      end
      check_val("t2_nz_vld_seen", {31'd0, nz_vld}, 32'd1);
      nz_rdy = 1'b0;
      h_row = nz_row;
      h_col = nz_col;
      h_val = nz_val;
      check_val("t2_first_nz", {12'd0, h_row, h_col, h_val}, 32'h0_BEEF);
      for (int c = 0; c < 5; c++) begin
         step();
         check_val($sformatf("t2_hold%0d", c), {12'd0, nz_row, nz_col, nz_val}, {12'd0, h_row, h_col, h_val});
         check_val($sformatf("t2_vld%0d", c), {31'd0, nz_vld}, 32'd1);
         check_val($sformatf("t2_rrdy%0d", c), {31'd0, rand_rdy}, 32'd0);
      end
      nz_rdy = 1'b1;
      wait_done("t2");
      check_run("t2", 0, 16'hBEEF);

      // ptr back-pressure in the first PTR state.
      rand_x1 = 32'hFFFF_FFFF;
      rand_z1 = 32'h0001_0000;
      ptr_rdy = 1'b0;
      start_run();
      for (int c = 0; c < 3; c++) begin
         check_val($sformatf("t3_pvld%0d", c), {31'd0, ptr_vld}, 32'd1);
         check_val($sformatf("t3_pdat%0d", c), {25'd0, ptr_idx, ptr_val}, 32'd0);
         check_val($sformatf("t3_rrdy%0d", c), {31'd0, rand_rdy}, 32'd0);
         step();
      end
      ptr_rdy = 1'b1;
      wait_done("t3");
      check_run("t3", 1, 16'h0001);

      // start while busy is ignored; a second start after done reruns identically.
      rand_x1 = 32'h8000_0000;
      rand_z1 = 32'h1234_0000;
      start_run();
      repeat (4) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("t4a");
      repeat (3) step();
      check_run("t4a", 1, 16'h1234);
      start_run();
      wait_done("t4b");
      check_run("t4b", 1, 16'h1234);

      // Asynchronous reset while emitting column 2.
      start_run();
      n = 0;
      while (!(ptr_vld && ptr_idx == 3'd2) && n < 100) begin
         step();
         n++;
      end
      check_val("t5_reach_col2", {29'd0, ptr_idx}, 32'd2);
      step();
      step();
      check_val("t5_in_emit", {29'd0, busy, nz_vld, nz_col == 2'd2}, 32'h7);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("t5_async_reset");
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check_val($sformatf("t5_idle%0d", c), {28'd0, busy, done, nz_vld, ptr_vld}, 32'd0);
      end
      start_run();
      check_val("t5_restart_ptr", {28'd0, ptr_vld, ptr_idx}, 32'h8);
      wait_done("t5");
      check_run("t5", 1, 16'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
